// File: rtl/pointmul_naf_ctrl.sv
// rtl/pointmul_naf_ctrl.sv - NAF double-and-add/subtract scalar point multiplication for SM2
// Holds the Jacobian double/add unit and the controller that sequences one of each.

module pm_jac_unit #(
  parameter bit           ADD_MODE = 1'b0,
  parameter int           LAT      = 4,
  parameter logic [255:0] P_SM2    = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [255:0] ax,
  input  logic [255:0] ay,
  input  logic [255:0] az,
  input  logic [255:0] bx,
  input  logic [255:0] by,
  input  logic [255:0] bz,
  output logic         done,
  output logic [255:0] rx,
  output logic [255:0] ry,
  output logic [255:0] rz
);
  typedef logic [255:0] fe_t;
  typedef struct packed { fe_t x; fe_t y; fe_t z; } pt_t;

  function automatic fe_t fmul(input fe_t a, input fe_t b);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, P_SM2};
    return fe_t'(t);
  endfunction

  function automatic fe_t fadd(input fe_t a, input fe_t b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_SM2}) s = s - {1'b0, P_SM2};
    return s[255:0];
  endfunction

  function automatic fe_t fsub(input fe_t a, input fe_t b);
    return (a >= b) ? (a - b) : (a + (P_SM2 - b));
  endfunction

  // Doubling specialised for a = -3; Z = 0 stays at Z = 0.
  function automatic pt_t pdbl(input pt_t a);
    fe_t delta, gamma, beta4, alpha, t, g2, g8;
    pt_t r;
    delta = fmul(a.z, a.z);
    gamma = fmul(a.y, a.y);
    beta4 = fmul(a.x, gamma);
    beta4 = fadd(beta4, beta4);
    beta4 = fadd(beta4, beta4);
    t     = fmul(fsub(a.x, delta), fadd(a.x, delta));
    alpha = fadd(t, fadd(t, t));
    r.x   = fsub(fmul(alpha, alpha), fadd(beta4, beta4));
    r.z   = fsub(fsub(fmul(fadd(a.y, a.z), fadd(a.y, a.z)), gamma), delta);
    g2    = fmul(gamma, gamma);
    g8    = fadd(g2, g2);
    g8    = fadd(g8, g8);
    g8    = fadd(g8, g8);
    r.y   = fsub(fmul(alpha, fsub(beta4, r.x)), g8);
    return r;
  endfunction

  function automatic pt_t padd(input pt_t a, input pt_t b);
    fe_t z1z1, z2z2, u1, u2, s1, s2, hh, rr, h2, h3, v;
    pt_t r;
    z1z1 = fmul(a.z, a.z);
    z2z2 = fmul(b.z, b.z);
    u1   = fmul(a.x, z2z2);
    u2   = fmul(b.x, z1z1);
    s1   = fmul(a.y, fmul(b.z, z2z2));
    s2   = fmul(b.y, fmul(a.z, z1z1));
    hh   = fsub(u2, u1);
    rr   = fsub(s2, s1);
    h2   = fmul(hh, hh);
    h3   = fmul(hh, h2);
    v    = fmul(u1, h2);
    r.x  = fsub(fsub(fmul(rr, rr), h3), fadd(v, v));
    r.y  = fsub(fmul(rr, fsub(v, r.x)), fmul(s1, h3));
    r.z  = fmul(fmul(a.z, b.z), hh);
    // Equal x: either the same point (double) or opposite points (infinity).
    if (hh == '0) r = (rr == '0) ? pdbl(a) : '{x: 256'd1, y: 256'd1, z: 256'd0};
    if (b.z == '0) r = a;
    if (a.z == '0) r = b;
    return r;
  endfunction

  pt_t        res;
  logic       busy;
  logic [7:0] cnt;

  always_comb begin
    res = ADD_MODE ? padd('{x: ax, y: ay, z: az}, '{x: bx, y: by, z: bz})
                   : pdbl('{x: ax, y: ay, z: az});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      cnt  <= 8'd0;
      done <= 1'b0;
      rx   <= '0;
      ry   <= '0;
      rz   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        {rx, ry, rz} <= res;
        busy         <= 1'b1;
        cnt          <= 8'(LAT);
      end else if (busy) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

module pointmul_naf_ctrl #(
  parameter int           NMAX  = 512,
  parameter logic [255:0] P_SM2 = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [255:0]      x1,
  input  logic [255:0]      y1,
  input  logic [255:0]      z1,
  input  logic [2*NMAX-1:0] h,
  input  logic [31:0]       hlength,
  input  logic              start,
  output logic [255:0]      x2,
  output logic [255:0]      y2,
  output logic [255:0]      z2,
  output logic              done
);
  localparam int IW      = $clog2(NMAX);
  localparam int DBL_LAT = 4;
  localparam int ADD_LAT = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DBL, S_DBL_W, S_ADD, S_ADD_W, S_NEXT, S_FIN
  } state_t;

  state_t            state, state_nx;
  logic [255:0]      px, py, pz, npy, qx, qy, qz;
  logic              inf;
  logic [2*NMAX-1:0] h_reg;
  logic [IW:0]       len, len_in;
  logic [IW-1:0]     idx;
  logic [1:0]        digit;
  logic              dbl_start, dbl_done, add_start, add_done;
  logic [255:0]      dbl_x, dbl_y, dbl_z, add_x, add_y, add_z;
  logic [255:0]      neg_y1, opy;

  always_comb begin
    len_in = (hlength > 32'(NMAX)) ? (IW+1)'(NMAX) : hlength[IW:0];
    neg_y1 = (y1 == '0) ? '0 : (P_SM2 - y1);
    opy    = digit[1] ? npy : py;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    dbl_start = 1'b0;
    add_start = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = (len == '0) ? S_FIN : S_DBL;
      S_DBL: begin
        if (inf) state_nx = S_ADD;
        else begin
          dbl_start = 1'b1;
          state_nx  = S_DBL_W;
        end
      end
      S_DBL_W: if (dbl_done) state_nx = S_ADD;
      S_ADD: begin
        // digit[0] clear covers both 0 and the reserved code 10.
        if (!digit[0] || inf) state_nx = S_NEXT;
        else begin
          add_start = 1'b1;
          state_nx  = S_ADD_W;
        end
      end
      S_ADD_W: if (add_done) state_nx = S_NEXT;
      S_NEXT:  state_nx = (idx == '0) ? S_FIN : S_LOAD;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px <= '0; py <= '0; pz <= '0; npy <= '0;
      qx <= '0; qy <= '0; qz <= '0;
      inf   <= 1'b1;
      h_reg <= '0;
      len   <= '0;
      idx   <= '0;
      digit <= 2'b00;
      x2 <= '0; y2 <= '0; z2 <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          px    <= x1;
          py    <= y1;
          pz    <= z1;
          npy   <= neg_y1;
          h_reg <= h;
          len   <= len_in;
          idx   <= IW'(len_in - (IW+1)'(1));
          inf   <= 1'b1;
        end
        S_LOAD:  digit <= h_reg[{idx, 1'b0} +: 2];
        S_DBL_W: if (dbl_done) begin
          qx <= dbl_x; qy <= dbl_y; qz <= dbl_z;
        end
        S_ADD: if (digit[0] && inf) begin
          qx  <= px; qy <= opy; qz <= pz;
          inf <= 1'b0;
        end
        S_ADD_W: if (add_done) begin
          qx <= add_x; qy <= add_y; qz <= add_z;
        end
        S_NEXT: if (idx != '0) idx <= idx - IW'(1);
        S_FIN: begin
          x2   <= inf ? 256'd1 : qx;
          y2   <= inf ? 256'd1 : qy;
          z2   <= inf ? 256'd0 : qz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  pm_jac_unit #(.ADD_MODE(1'b0), .LAT(DBL_LAT), .P_SM2(P_SM2)) u_dbl (
    .clk(clk), .rstn(rstn), .start(dbl_start),
    .ax(qx), .ay(qy), .az(qz), .bx('0), .by('0), .bz('0),
    .done(dbl_done), .rx(dbl_x), .ry(dbl_y), .rz(dbl_z)
  );

  pm_jac_unit #(.ADD_MODE(1'b1), .LAT(ADD_LAT), .P_SM2(P_SM2)) u_add (
    .clk(clk), .rstn(rstn), .start(add_start),
    .ax(qx), .ay(qy), .az(qz), .bx(px), .by(opy), .bz(pz),
    .done(add_done), .rx(add_x), .ry(add_y), .rz(add_z)
  );
endmodule

// File: tb/tb_pointmul_naf_ctrl.sv
// tb/tb_pointmul_naf_ctrl.sv - self-checking bench for pointmul_naf_ctrl
// Reference: affine group law with field inversion, scalar taken from the digit values.

module tb_pointmul_naf_ctrl;
  localparam logic [255:0] PP = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [255:0] GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;

  typedef struct { logic [255:0] x; logic [255:0] y; bit inf; } aff_t;
  typedef struct { string name; logic [1023:0] h; int len; longint k; } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [255:0]  x1, y1, z1;
  logic [1023:0] h;
  logic [31:0]   hlength;
  logic          start;
  logic [255:0]  x2, y2, z2;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  pointmul_naf_ctrl dut (
    .clk(clk), .rstn(rstn), .x1(x1), .y1(y1), .z1(z1), .h(h), .hlength(hlength),
    .start(start), .x2(x2), .y2(y2), .z2(z2), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, PP};
    return t[255:0];
  endfunction

  function automatic logic [255:0] ma(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, PP}) t = t - {1'b0, PP};
    return t[255:0];
  endfunction

  function automatic logic [255:0] ms(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : a + (PP - b);
  endfunction

  function automatic logic [255:0] minv(input logic [255:0] a);
    logic [255:0] e, r;
    e = PP - 256'd2;
    r = 256'd1;
    for (int i = 255; i >= 0; i--) begin
      r = mm(r, r);
      if (e[i]) r = mm(r, a);
    end
    return r;
  endfunction

  function automatic aff_t aff_dbl(input aff_t a);
    aff_t r;
    logic [255:0] lam, num;
    if (a.inf || a.y == '0) begin
      r.inf = 1'b1; r.x = '0; r.y = '0;
    end else begin
      num = ma(ma(mm(a.x, a.x), mm(a.x, a.x)), mm(a.x, a.x));
      num = ma(num, PP - 256'd3);
      lam = mm(num, minv(ma(a.y, a.y)));
      r.inf = 1'b0;
      r.x = ms(mm(lam, lam), ma(a.x, a.x));
      r.y = ms(mm(lam, ms(a.x, r.x)), a.y);
    end
    return r;
  endfunction

  function automatic aff_t aff_add(input aff_t a, input aff_t b);
    aff_t r;
    logic [255:0] lam;
    if (a.inf) r = b;
    else if (b.inf) r = a;
    else if (a.x == b.x) begin
      if (ma(a.y, b.y) == '0) begin
        r.inf = 1'b1; r.x = '0; r.y = '0;
      end else r = aff_dbl(a);
    end else begin
      lam = mm(ms(b.y, a.y), minv(ms(b.x, a.x)));
      r.inf = 1'b0;
      r.x = ms(ms(mm(lam, lam), a.x), b.x);
      r.y = ms(mm(lam, ms(a.x, r.x)), a.y);
    end
    return r;
  endfunction

  function automatic aff_t aff_mul(input logic [513:0] mag, input bit neg, input aff_t base);
    aff_t r, acc;
    logic [513:0] m;
    r.inf = 1'b1; r.x = '0; r.y = '0;
    acc = base;
    m = mag;
    while (m != '0) begin
      if (m[0]) r = aff_add(r, acc);
      m = m >> 1;
      if (m != '0) acc = aff_dbl(acc);
    end
    if (neg && !r.inf && r.y != '0) r.y = PP - r.y;
    return r;
  endfunction

  task automatic chk_fe(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_aff(input string name, input aff_t e);
    aff_t a;
    logic [255:0] zi, zi2;
    a.inf = (z2 == '0);
    a.x = '0; a.y = '0;
    if (!a.inf) begin
      zi  = minv(z2);
      zi2 = mm(zi, zi);
      a.x = mm(x2, zi2);
      a.y = mm(mm(y2, zi2), zi);
    end
    chk_int({name, "_inf"}, longint'(a.inf), longint'(e.inf));
    if (e.inf) begin
      chk_fe({name, "_x_inf"}, x2, 256'd1);
      chk_fe({name, "_y_inf"}, y2, 256'd1);
      chk_fe({name, "_z_inf"}, z2, 256'd0);
    end else if (!a.inf) begin
      chk_fe({name, "_x"}, a.x, e.x);
      chk_fe({name, "_y"}, a.y, e.y);
    end
  endtask

  task automatic wait_done(input string name, output int cyc);
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 20000 && !ok) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done want done within 20000 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [255:0] px, input logic [255:0] py,
                        input logic [255:0] pz, input logic [1023:0] ph, input int plen,
                        output int cyc);
    @(negedge clk);
    x1 = px; y1 = py; z1 = pz; h = ph; hlength = 32'(plen); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x1 = ~px; y1 = ~py; z1 = ~pz; h = ~ph; hlength = 32'd3;
    wait_done(name, cyc);
    chk_aff(name, aff_t'{x: '0, y: '0, inf: 1'b1});
  endtask

  vec_t vecs[9];
  aff_t g, e, base;

  initial begin
    int cyc, extra, len, m;
    longint k;
    logic [1023:0] hv;
    logic [255:0] lam, jx, jy, jz, save_x, save_y, save_z;
    logic [1:0] d;

    g.x = GX; g.y = GY; g.inf = 1'b0;
    vecs[0] = '{"six",       1024'h4C,  4, 6};
    vecs[1] = '{"one",       1024'h1,   1, 1};
    vecs[2] = '{"minus_one", 1024'h3,   1, -1};
    vecs[3] = '{"len_zero",  1024'h4C,  0, 0};
    vecs[4] = '{"all_zero",  1024'h0,   8, 0};
    vecs[5] = '{"reserved",  1024'h6,   2, 2};
    vecs[6] = '{"nineteen",  1024'h113, 5, 19};
    vecs[7] = '{"len_mask",  1024'h44C, 4, 6};
    vecs[8] = '{"minus_7",   1024'hC1,  4, -7};

    rstn = 1'b0; start = 1'b0; x1 = '0; y1 = '0; z1 = '0; h = '0; hlength = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_done", longint'(done), 0);
    chk_fe("reset_x2", x2, '0);
    chk_fe("reset_y2", y2, '0);
    chk_fe("reset_z2", z2, '0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      e = aff_mul(514'(vecs[i].k < 0 ? -vecs[i].k : vecs[i].k), vecs[i].k < 0, g);
      @(negedge clk);
      x1 = GX; y1 = GY; z1 = 256'd1; h = vecs[i].h; hlength = 32'(vecs[i].len); start = 1'b1;
      @(negedge clk);
      start = 1'b0; x1 = '0; y1 = '0; h = '0;
      wait_done(vecs[i].name, cyc);
      chk_aff(vecs[i].name, e);
      @(negedge clk);
      chk_int({vecs[i].name, "_done_width"}, longint'(done), 0);
    end

    @(negedge clk);
    x1 = GX; y1 = GY; z1 = 256'd1; h = 1024'h1; hlength = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("raw_plus", cyc);
    chk_int("raw_plus_latency", cyc, 5);
    chk_fe("raw_plus_x", x2, GX);
    chk_fe("raw_plus_y", y2, GY);
    chk_fe("raw_plus_z", z2, 256'd1);

    @(negedge clk);
    x1 = GX; y1 = GY; z1 = 256'd1; h = 1024'h3; hlength = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("raw_minus", cyc);
    chk_fe("raw_minus_x", x2, GX);
    chk_fe("raw_minus_y", y2, PP - GY);
    chk_fe("raw_minus_z", z2, 256'd1);

    // A second start while busy must not disturb the running job.
    e = aff_mul(514'd19, 1'b0, g);
    @(negedge clk);
    x1 = GX; y1 = GY; z1 = 256'd1; h = 1024'h113; hlength = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    x1 = GY; y1 = GX; h = 1024'h1; hlength = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", cyc);
    chk_aff("busy_start", e);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk_int("busy_start_extra_done", extra, 0);

    hv = '0;
    hv[1023:1022] = 2'b01;
    e = aff_mul(514'(1) << 511, 1'b0, g);
    @(negedge clk);
    x1 = GX; y1 = GY; z1 = 256'd1; h = hv; hlength = 32'd600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("clamp", cyc);
    chk_aff("clamp", e);

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 10);
      hv = '0;
      for (int i = 0; i < 40; i++) hv[2*i +: 2] = 2'($urandom_range(0, 3));
      k = 0;
      for (int i = len - 1; i >= 0; i--) begin
        d = hv[2*i +: 2];
        k = 2 * k + ((d == 2'b01) ? 1 : (d == 2'b11) ? -1 : 0);
      end
      m = $urandom_range(1, 9);
      base = aff_mul(514'(m), 1'b0, g);
      lam = '0;
      for (int i = 0; i < 8; i++) lam[32*i +: 32] = $urandom;
      lam = mm(lam, 256'd1);
      if (lam == '0) lam = 256'd5;
      jx = mm(base.x, mm(lam, lam));
      jy = mm(base.y, mm(lam, mm(lam, lam)));
      jz = lam;
      e = aff_mul(514'(k < 0 ? -k : k), k < 0, base);
      @(negedge clk);
      x1 = jx; y1 = jy; z1 = jz; h = hv; hlength = 32'(len); start = 1'b1;
      @(negedge clk);
      start = 1'b0; x1 = ~jx; y1 = ~jy; z1 = ~jz; h = ~hv;
      wait_done($sformatf("rand%0d", t), cyc);
      chk_aff($sformatf("rand%0d", t), e);
    end

    save_x = x2; save_y = y2; save_z = z2;
    @(negedge clk);
    x1 = GX; y1 = GY; z1 = 256'd1; h = 1024'h113; hlength = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_int("abort_done", longint'(done), 0);
    chk_fe("abort_x2", x2, '0);
    chk_fe("abort_y2", y2, '0);
    chk_fe("abort_z2", z2, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk_int("abort_no_done", extra, 0);
    chk_fe("abort_hold_x2", x2, '0);

    run_op("post_abort_zero", GX, GY, 256'd1, 1024'h0, 3, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
